// File: rtl/soc1_sw_poll_master.sv
// soc1_sw_poll_master
//   Avalon-MM read master that polls the 10-bit switch PIO data register on
//   a fixed period. It debounces the sampled value and hands game logic a
//   stable switch vector, a one-cycle change pulse and the mask of the bits
//   that changed.
//
//   Handshake: avm_read is held high until the first cycle in which
//   avm_waitrequest is low, and the read is accepted in that cycle.
//   avm_waitrequest is meaningless while avm_read is low. After acceptance
//   the master waits for avm_readdatavalid. A valid may arrive in the accept
//   cycle itself. Only one read is ever outstanding. A valid that arrives
//   while no read is outstanding is ignored.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              1 = polling allowed
//   avm_address         constant BASE_ADDR
//   avm_read            read request
//   avm_waitrequest     slave stall
//   avm_readdata        read data; only [SW_W-1:0] is used
//   avm_readdatavalid   read data valid
//   sw_value            debounced switch vector
//   sw_changed          one-cycle pulse when sw_value updates
//   sw_change_mask      old ^ new of the last update, held until the next one
//   rd_timeout          one-cycle pulse when a read is abandoned
//   dbg_state           current FSM state (IDLE=0, REQ=1, WAIT=2, UPDATE=3)
module soc1_sw_poll_master #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                SW_W       = 10,
    parameter int                POLL_DIV   = 50000,
    parameter int                STABLE_CNT = 4,
    parameter int                TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [SW_W-1:0]   sw_value,
    output logic              sw_changed,
    output logic [SW_W-1:0]   sw_change_mask,
    output logic              rd_timeout,
    output logic [1:0]        dbg_state
);

    localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [SW_W-1:0]  sample_q, sample_d;
    logic [SW_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW_W-1:0]  value_q, value_d;
    logic [SW_W-1:0]  mask_q, mask_d;
    logic             changed_q, changed_d;

    logic             tick;
    logic             data_take;
    logic [SW_W-1:0]  cand_new;
    logic [CNT_W-1:0] cnt_new;
    logic             unused_hi;

    // Bits above the switch field carry nothing of interest.
    assign unused_hi = ^avm_readdata[31:SW_W];

    assign avm_address    = BASE_ADDR;
    assign sw_value       = value_q;
    assign sw_changed     = changed_q;
    assign sw_change_mask = mask_q;
    assign dbg_state      = state_q;

    // Poll divider: counts 0..POLL_DIV-1 while enabled. The tick is the cycle
    // in which it wraps back to 0. It is parked at 0 while disabled.
    always_comb begin
        tick  = enable && (div_q == DIV_LAST);
        div_d = div_q;
        if (!enable || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Transaction FSM. A tick is acted on only in IDLE, so ticks that fall
    // inside a transaction are simply lost. rd_timeout fires in the WAIT
    // cycle where the count runs out with no valid data. A valid in that
    // same cycle still wins.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        sample_d   = sample_q;
        avm_read   = 1'b0;
        rd_timeout = 1'b0;
        data_take  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    to_cnt_d = '0;
                    if (avm_readdatavalid) begin
                        data_take = 1'b1;
                        state_d   = S_UPDATE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    data_take = 1'b1;
                    state_d   = S_UPDATE;
                end else if (to_cnt_q == TO_LAST) begin
                    rd_timeout = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (data_take) begin
            sample_d = avm_readdata[SW_W-1:0];
        end
    end

    // Debounce. The stable count saturates at STABLE_CNT. A value is accepted
    // only when it differs from the current output, so a value that stays
    // the same never retriggers the change pulse.
    always_comb begin
        if (sample_q == cand_q) begin
            cand_new = cand_q;
            cnt_new  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cand_new = sample_q;
            cnt_new  = CNT_W'(1);
        end

        cand_d    = cand_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        mask_d    = mask_q;
        changed_d = 1'b0;
        if (state_q == S_UPDATE) begin
            cand_d = cand_new;
            cnt_d  = cnt_new;
            if ((cnt_new == CNT_MAX) && (cand_new != value_q)) begin
                value_d   = cand_new;
                mask_d    = value_q ^ cand_new;
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            to_cnt_q  <= '0;
            sample_q  <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            mask_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            to_cnt_q  <= to_cnt_d;
            sample_q  <= sample_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            mask_q    <= mask_d;
            changed_q <= changed_d;
        end
    end

endmodule

// File: tb/tb_soc1_sw_poll_master.sv
// Bench for soc1_sw_poll_master. Two instances share one bus stimulus. One
// uses STABLE_CNT=3 and the other STABLE_CNT=1. A transaction-level model
// predicts every output on every cycle, and directed checks pin absolute
// event timings.
module tb_soc1_sw_poll_master;

    localparam int          SW_W = 10;
    localparam int          PD   = 8;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h0001_0040;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable  = 1'b0;
    logic            wr      = 1'b0;
    logic            rdv     = 1'b0;
    logic [31:0]     rdata   = '0;
    logic [31:0]     addr3, addr1;
    logic            read3, read1, chg3, chg1, to3, to1;
    logic [SW_W-1:0] val3, val1, mask3, mask1;
    logic [1:0]      st3, st1;

    soc1_sw_poll_master #(
        .ADDR_W(32), .BASE_ADDR(BASE), .SW_W(SW_W), .POLL_DIV(PD),
        .STABLE_CNT(3), .TIMEOUT(TO)
    ) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(addr3), .avm_read(read3), .avm_waitrequest(wr),
        .avm_readdata(rdata), .avm_readdatavalid(rdv),
        .sw_value(val3), .sw_changed(chg3), .sw_change_mask(mask3),
        .rd_timeout(to3), .dbg_state(st3)
    );

    soc1_sw_poll_master #(
        .ADDR_W(32), .BASE_ADDR(BASE), .SW_W(SW_W), .POLL_DIV(PD),
        .STABLE_CNT(1), .TIMEOUT(TO)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wr),
        .avm_readdata(rdata), .avm_readdatavalid(rdv),
        .sw_value(val1), .sw_changed(chg1), .sw_change_mask(mask1),
        .rd_timeout(to1), .dbg_state(st1)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // ---------------- slave driver ----------------
    int          cfg_stall = 0;
    logic [31:0] resp_q[$];
    int          lat_q[$];
    int          stray_at = -1;
    logic [31:0] stray_data = '0;

    initial begin
        bit          s_in_req;
        int          s_stall_left;
        int          s_deliver_at;
        int          lat;
        logic [31:0] s_data;
        s_in_req = 0; s_stall_left = 0; s_deliver_at = -1; s_data = '0; lat = -1;
        forever begin
            @(posedge clk); #1;
            rdv   = 1'b0;
            rdata = $urandom;
            if (!reset_n) begin
                wr = 1'b0; s_in_req = 0; s_deliver_at = -1;
            end else begin
                if (read3) begin
                    if (!s_in_req) begin
                        s_in_req = 1; s_stall_left = cfg_stall;
                    end
                    if (s_stall_left > 0) begin
                        wr = 1'b1; s_stall_left--;
                    end else begin
                        wr = 1'b0; s_in_req = 0;
                        if (resp_q.size() > 0) s_data = resp_q.pop_front();
                        else s_data = 32'h0;
                        if (lat_q.size() > 0) lat = lat_q.pop_front();
                        else lat = -1;
                        if (lat >= 0) s_deliver_at = cyc + lat;
                    end
                end else begin
                    // waitrequest noise while no read is requested
                    wr = 1'($urandom_range(0, 1));
                    s_in_req = 0;
                end
                if (cyc == s_deliver_at) begin
                    rdv = 1'b1; rdata = s_data; s_deliver_at = -1;
                end else if (cyc == stray_at) begin
                    rdv = 1'b1; rdata = stray_data;
                end
            end
        end
    end

    // ---------------- model + scoreboard ----------------
    logic [SW_W-1:0] exp_q3[$], exp_q1[$];
    int              exp_c3[$], exp_c1[$];
    int  m_div, m_acc, m_free_at;
    bit  m_req, m_wait;
    logic [SW_W-1:0] m_cand3, m_tgt3, m_sw3, m_mask3;
    logic [SW_W-1:0] m_cand1, m_tgt1, m_sw1, m_mask1;
    int  m_cnt3, m_cnt1;

    // observed events for directed checks
    int rd_start[$], rd_len[$], chg3_c[$], chg1_c[$], to_c[$];

    task automatic model_reset();
        m_div = 0; m_acc = 0; m_free_at = 0; m_req = 0; m_wait = 0;
        m_cand3 = '0; m_tgt3 = '0; m_sw3 = '0; m_mask3 = '0; m_cnt3 = 0;
        m_cand1 = '0; m_tgt1 = '0; m_sw1 = '0; m_mask1 = '0; m_cnt1 = 0;
        exp_q3.delete(); exp_q1.delete(); exp_c3.delete(); exp_c1.delete();
    endtask

    task automatic debounce(input logic [SW_W-1:0] s, input int st,
                            inout logic [SW_W-1:0] cand, inout int cnt,
                            inout logic [SW_W-1:0] tgt, output bit acc);
        acc = 0;
        if (s == cand) cnt = (cnt < st) ? cnt + 1 : st;
        else begin cand = s; cnt = 1; end
        if (cnt == st && cand != tgt) begin tgt = cand; acc = 1; end
    endtask

    initial begin
        int              c, last_start;
        bit              prev_read, exp_to, e_chg3, e_chg1, tick_m, acc;
        logic [SW_W-1:0] nv;
        prev_read = 0; last_start = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                model_reset();
                prev_read = 0;
            end else begin
                c = cyc;
                exp_to = m_wait && !rdv && (c == m_acc + TO);
                e_chg3 = 0;
                if (exp_c3.size() > 0 && exp_c3[0] == c) begin
                    void'(exp_c3.pop_front());
                    nv = exp_q3.pop_front();
                    m_mask3 = m_sw3 ^ nv; m_sw3 = nv; e_chg3 = 1;
                end
                e_chg1 = 0;
                if (exp_c1.size() > 0 && exp_c1[0] == c) begin
                    void'(exp_c1.pop_front());
                    nv = exp_q1.pop_front();
                    m_mask1 = m_sw1 ^ nv; m_sw1 = nv; e_chg1 = 1;
                end
                check("read3", read3, m_req);
                check("read1", read1, m_req);
                check("addr3", addr3, BASE);
                check("addr1", addr1, BASE);
                check("value3", val3, m_sw3);
                check("mask3", mask3, m_mask3);
                check("changed3", chg3, e_chg3);
                check("timeout3", to3, exp_to);
                check("value1", val1, m_sw1);
                check("mask1", mask1, m_mask1);
                check("changed1", chg1, e_chg1);
                check("timeout1", to1, exp_to);

                // advance the model with this cycle's inputs
                tick_m = enable && (m_div == PD - 1) && !m_req && !m_wait && (c >= m_free_at);
                if (m_req && !wr) begin
                    m_req = 0; m_wait = 1; m_acc = c;
                end
                if (m_wait) begin
                    if (rdv) begin
                        debounce(rdata[SW_W-1:0], 3, m_cand3, m_cnt3, m_tgt3, acc);
                        if (acc) begin exp_q3.push_back(m_cand3); exp_c3.push_back(c + 2); end
                        debounce(rdata[SW_W-1:0], 1, m_cand1, m_cnt1, m_tgt1, acc);
                        if (acc) begin exp_q1.push_back(m_cand1); exp_c1.push_back(c + 2); end
                        m_wait = 0; m_free_at = c + 2;
                    end else if (c == m_acc + TO) begin
                        m_wait = 0; m_free_at = c + 1;
                    end
                end
                if (tick_m) m_req = 1;
                m_div = enable ? (m_div + 1) % PD : 0;

                if (read3 && !prev_read) begin rd_start.push_back(c); last_start = c; end
                if (!read3 && prev_read) rd_len.push_back(c - last_start);
                prev_read = read3;
                if (chg3) chg3_c.push_back(c);
                if (chg1) chg1_c.push_back(c);
                if (to3) to_c.push_back(c);
            end
        end
    end

    // ---------------- driver tasks ----------------
    int r = 0;

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #3; end
    endtask

    task automatic run_to(input int rel);
        while (cyc < r + rel) step(1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(3);
        resp_q.delete(); lat_q.delete();
        stray_at = -1; cfg_stall = 0;
        rd_start.delete(); rd_len.delete(); chg3_c.delete(); chg1_c.delete(); to_c.delete();
        reset_n = 1'b1;
        r = cyc;
    endtask

    task automatic push_rd(input logic [31:0] d, input int lat, input int n);
        repeat (n) begin resp_q.push_back(d); lat_q.push_back(lat); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        enable = 1'b1;
        step(2);
        check("rst_read", read3, 0);
        check("rst_value", val3, 0);
        check("rst_changed", chg3, 0);
        check("rst_mask", mask3, 0);
        check("rst_timeout", to3, 0);
        check("rst_state", st3, 0);

        // basic path: 0x2A5 every read, latency 1
        do_reset();
        push_rd(32'h0000_02A5, 1, 5);
        run_to(46);
        check("basic_first_read", qat(rd_start, 0) - r, 8);
        check("basic_second_read", qat(rd_start, 1) - r, 16);
        check("basic_read_count", rd_start.size(), 5);
        check("basic_read_len", qat(rd_len, 0), 1);
        check("basic_chg3_count", chg3_c.size(), 1);
        check("basic_chg3_cycle", qat(chg3_c, 0) - r, 27);
        check("basic_chg1_cycle", qat(chg1_c, 0) - r, 11);
        check("basic_value", val3, 10'h2A5);
        check("basic_mask", mask3, 10'h2A5);

        // bounce
        do_reset();
        push_rd(32'h1, 1, 1); push_rd(32'h0, 1, 1); push_rd(32'h1, 1, 3);
        run_to(46);
        check("bounce_chg3_count", chg3_c.size(), 1);
        check("bounce_chg3_cycle", qat(chg3_c, 0) - r, 43);
        check("bounce_value", val3, 10'h001);
        check("bounce_mask", mask3, 10'h001);
        check("bounce_chg1_count", chg1_c.size(), 3);

        // stall 5 cycles, latency 3
        do_reset();
        cfg_stall = 5;
        push_rd(32'h0000_0155, 3, 3);
        run_to(54);
        check("stall_read_len", qat(rd_len, 0), 6);
        check("stall_second_read", qat(rd_start, 1) - r, 24);
        check("stall_read_count", rd_start.size(), 3);
        check("stall_chg3_cycle", qat(chg3_c, 0) - r, 50);
        check("stall_value", val3, 10'h155);

        // timeout, late valid, candidate kept across an abandoned read
        do_reset();
        stray_at = r + 26; stray_data = 32'h0000_03FF;
        push_rd(32'h0, -1, 1); push_rd(32'h0AA, 1, 2); push_rd(32'h0, -1, 1); push_rd(32'h0AA, 1, 1);
        run_to(78);
        check("to_first", qat(to_c, 0) - r, 24);
        check("to_second", qat(to_c, 1) - r, 64);
        check("to_next_read", qat(rd_start, 1) - r, 32);
        check("to_read_count", rd_start.size(), 5);
        check("to_chg3_cycle", qat(chg3_c, 0) - r, 75);
        check("to_chg1_count", chg1_c.size(), 1);
        check("to_value1", val1, 10'h0AA);

        // upper bits ignored, then latency-0 data
        do_reset();
        push_rd(32'hFFFF_FC00, 1, 4); push_rd(32'h0000_03C3, 0, 3);
        run_to(37);
        check("upper_chg3_none", chg3_c.size(), 0);
        check("upper_chg1_none", chg1_c.size(), 0);
        check("upper_value", val3, 0);
        run_to(62);
        check("lat0_chg1_cycle", qat(chg1_c, 0) - r, 42);
        check("lat0_chg3_cycle", qat(chg3_c, 0) - r, 58);
        check("lat0_mask", mask3, 10'h3C3);

        // enable dropped mid-WAIT, then reset while avm_read is high
        do_reset();
        push_rd(32'h2A5, 1, 3); push_rd(32'h0F0, 5, 1);
        run_to(34);
        enable = 1'b0;
        run_to(70);
        check("en_read_count", rd_start.size(), 4);
        check("en_chg1_cycle", qat(chg1_c, 1) - r, 39);
        check("en_value1", val1, 10'h0F0);
        begin
            int e;
            cfg_stall = 5;
            push_rd(32'h111, 1, 1);
            enable = 1'b1;
            e = cyc;
            for (int i = 0; i < 20; i++) begin
                step(1);
                if (read3) break;
            end
            check("reen_read_cycle", cyc - e, 8);
        end
        step(2);
        reset_n = 1'b0;
        #1;
        check("arst_read3", read3, 0);
        check("arst_read1", read1, 0);
        check("arst_value3", val3, 0);
        check("arst_mask3", mask3, 0);
        check("arst_value1", val1, 0);
        check("arst_changed3", chg3, 0);
        check("arst_state", st3, 0);
        enable = 1'b0;
        do_reset();
        run_to(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
